// File: rtl/fir_axis_mc.sv
// fir_axis_mc: multichannel TDM FIR filter with AXI4-Stream in/out.
// Each channel has its own delay line. Coefficients are shared and runtime-loadable.
// The output is rounded (half toward +inf), saturated and held in a single output register.
module fir_axis_mc #(
  parameter int DATA_W    = 32,
  parameter int COEF_W    = 16,
  parameter int N_TAPS    = 8,
  parameter int N_CH      = 2,
  parameter int OUT_SHIFT = 15,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int A_W      = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [CH_W-1:0]   m_axis_tuser,
  input  logic              coef_we,
  input  logic [A_W-1:0]    coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              frame_err
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(N_TAPS);

  // Rounding constant 2^(OUT_SHIFT-1), or zero when no shift is applied.
  localparam logic signed [ACC_W:0] RND =
    ((ACC_W+1)'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  logic signed [DATA_W-1:0] x_q [N_CH][N_TAPS];
  logic signed [DATA_W-1:0] x_d [N_CH][N_TAPS];
  logic signed [COEF_W-1:0] c_q [N_TAPS];
  logic signed [COEF_W-1:0] c_d [N_TAPS];
  logic [CH_W-1:0]          ch_q, ch_d;
  logic                     m_valid_q, m_valid_d;
  logic [DATA_W-1:0]        m_data_q, m_data_d;
  logic                     m_last_q, m_last_d;
  logic [CH_W-1:0]          m_user_q, m_user_d;
  logic                     ferr_q, ferr_d;

  logic                     accept;
  logic signed [DATA_W-1:0] tap [N_TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    shifted;
  logic [DATA_W-1:0]        sat;

  assign s_axis_tready = !m_valid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Window of the active channel as it will look after the shift (new sample at tap 0).
  always_comb begin
    tap[0] = $signed(s_axis_tdata);
    for (int unsigned k = 1; k < N_TAPS; k++) begin
      tap[k] = x_q[ch_q][k-1];
    end
  end

  // Full-precision multiply-accumulate, then round, shift and saturate.
  always_comb begin
    acc = '0;
    for (int unsigned k = 0; k < N_TAPS; k++) begin
      acc = acc + ACC_W'(PROD_W'(tap[k]) * PROD_W'(c_q[k]));
    end
    rnd_sum = (ACC_W+1)'(acc) + RND;
    shifted = rnd_sum >>> OUT_SHIFT;
    if (shifted > SAT_MAX) begin
      sat = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat = shifted[DATA_W-1:0];
    end
  end

  // Next state: shift on accept, update the output register, apply coefficient writes.
  always_comb begin
    x_d       = x_q;
    c_d       = c_q;
    ch_d      = ch_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_user_d  = m_user_q;
    ferr_d    = ferr_q;

    if (accept) begin
      for (int unsigned k = 0; k < N_TAPS; k++) begin
        x_d[ch_q][k] = tap[k];
      end
      m_valid_d = 1'b1;
      m_data_d  = sat;
      m_last_d  = s_axis_tlast;
      m_user_d  = ch_q;
      if (s_axis_tlast || ch_q == LAST_CH) begin
        ch_d = '0;
      end else begin
        ch_d = ch_q + CH_W'(1);
      end
      if (s_axis_tlast && ch_q != LAST_CH) begin
        ferr_d = 1'b1;
      end
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end

    // Write lands after this edge, so a concurrent accept still uses the old value.
    if (coef_we && (int'(coef_addr) < N_TAPS)) begin
      c_d[coef_addr] = $signed(coef_data);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        for (int unsigned k = 0; k < N_TAPS; k++) begin
          x_q[c][k] <= '0;
        end
      end
      for (int unsigned k = 0; k < N_TAPS; k++) begin
        c_q[k] <= '0;
      end
      ch_q      <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_user_q  <= '0;
      ferr_q    <= 1'b0;
    end else begin
      x_q       <= x_d;
      c_q       <= c_d;
      ch_q      <= ch_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_user_q  <= m_user_d;
      ferr_q    <= ferr_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign frame_err     = ferr_q;

endmodule

// File: tb/tb_fir_axis_mc.sv
// Testbench for fir_axis_mc: directed tables, corner sequences and randomized
// traffic checked against a per-channel convolution model with a scoreboard.
module tb_fir_axis_mc;
  localparam int NT = 4;
  localparam int NC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DUT A: OUT_SHIFT = 0
  logic [15:0] s_tdata, m_tdata, coef_data;
  logic        s_tvalid, s_tready, s_tlast;
  logic        m_tvalid, m_tready, m_tlast, coef_we, frame_err;
  logic [0:0]  m_tuser;
  logic [1:0]  coef_addr;

  // DUT B: OUT_SHIFT = 1
  logic [15:0] s_tdata_b, m_tdata_b, coef_data_b;
  logic        s_tvalid_b, s_tready_b, s_tlast_b;
  logic        m_tvalid_b, m_tready_b, m_tlast_b, coef_we_b, frame_err_b;
  logic [0:0]  m_tuser_b;
  logic [1:0]  coef_addr_b;

  fir_axis_mc #(.DATA_W(16), .COEF_W(16), .N_TAPS(NT), .N_CH(NC), .OUT_SHIFT(0)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .frame_err(frame_err)
  );

  fir_axis_mc #(.DATA_W(16), .COEF_W(16), .N_TAPS(NT), .N_CH(NC), .OUT_SHIFT(1)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata_b), .s_axis_tvalid(s_tvalid_b), .s_axis_tready(s_tready_b),
    .s_axis_tlast(s_tlast_b),
    .m_axis_tdata(m_tdata_b), .m_axis_tvalid(m_tvalid_b), .m_axis_tready(m_tready_b),
    .m_axis_tlast(m_tlast_b), .m_axis_tuser(m_tuser_b),
    .coef_we(coef_we_b), .coef_addr(coef_addr_b), .coef_data(coef_data_b),
    .frame_err(frame_err_b)
  );

  typedef struct { int d; int u; bit l; } exp_t;
  typedef struct { logic [15:0] din; bit last; int exp; int user; bit elast; } vec_t;
  typedef struct { int din; int exp; } rvec_t;

  int    hist [NC][NT];
  int    mc [NT];
  int    mch;
  bit    mferr;
  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  bit    acc_flag;
  int    ready_mode;
  int    stall_end;
  int    cyc = 0;
  bit    prev_stall;
  logic [15:0] held_d;
  logic  held_l;
  logic [0:0] held_u;

  function automatic int sat_round(longint a, int sh);
    longint r;
    r = a;
    if (sh > 0) r = (r + (longint'(1) << (sh - 1))) >>> sh;
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return int'(r);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < NT; k++) hist[c][k] = 0;
    for (int k = 0; k < NT; k++) mc[k] = 0;
    mch = 0;
    mferr = 0;
    q.delete();
    prev_stall = 0;
  endtask

  // Observe DUT A at the falling edge: what will happen at the coming rising edge.
  task automatic monitor();
    exp_t   e;
    longint a;
    acc_flag = 0;
    if (rst) begin
      model_clear();
      return;
    end
    chk("frame_err", frame_err, mferr);
    chk("s_tready", s_tready, !m_tvalid || m_tready);
    if (prev_stall) begin
      chk("hold_valid", m_tvalid, 1);
      chk("hold_data", m_tdata, held_d);
      chk("hold_last", m_tlast, held_l);
      chk("hold_user", m_tuser, held_u);
    end
    if (m_tvalid && m_tready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        e = q.pop_front();
        chk("out_data", longint'($signed(m_tdata)), e.d);
        chk("out_user", m_tuser, e.u);
        chk("out_last", m_tlast, e.l);
      end
    end
    prev_stall = m_tvalid && !m_tready;
    held_d = m_tdata;
    held_l = m_tlast;
    held_u = m_tuser;
    acc_flag = s_tvalid && s_tready;
    if (acc_flag) begin
      for (int k = NT - 1; k >= 1; k--) hist[mch][k] = hist[mch][k-1];
      hist[mch][0] = $signed(s_tdata);
      a = 0;
      for (int k = 0; k < NT; k++) a += longint'(hist[mch][k]) * longint'(mc[k]);
      e.d = sat_round(a, 0);
      e.u = mch;
      e.l = s_tlast;
      q.push_back(e);
      if (s_tlast && mch != NC - 1) mferr = 1;
      mch = s_tlast ? 0 : (mch + 1) % NC;
    end
    if (coef_we) mc[coef_addr] = $signed(coef_data);
  endtask

  // One clock: choose ready, observe at negedge, return #1 after the rising edge.
  task automatic step();
    if (ready_mode == 1) m_tready = 1'($urandom_range(0, 1));
    else if (ready_mode == 2) m_tready = (cyc >= stall_end);
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_beat(input logic [15:0] d, input bit last);
    int n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    n = 0;
    do begin
      step();
      coef_we = 1'b0;
      n++;
    end while (!acc_flag && n < 50);
    chk("send_timeout", acc_flag, 1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic set_coef(input int addr, input int val);
    coef_we   = 1'b1;
    coef_addr = 2'(addr);
    coef_data = 16'(val);
    step();
    coef_we = 1'b0;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic load_1234();
    for (int k = 0; k < NT; k++) set_coef(k, k + 1);
  endtask

  task automatic drain();
    ready_mode = 0;
    m_tready   = 1'b1;
    s_tvalid   = 1'b0;
    repeat (3) step();
  endtask

  vec_t  t1 [10];
  rvec_t rt [10];

  task automatic run_conv();
    for (int i = 0; i < 10; i++) begin
      send_beat(t1[i].din, t1[i].last);
      chk("conv_data", longint'($signed(m_tdata)), t1[i].exp);
      chk("conv_user", m_tuser, t1[i].user);
      chk("conv_last", m_tlast, t1[i].elast);
    end
    chk("conv_frame_err", frame_err, 0);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      t1[2*i]   = '{din: (i == 0) ? 16'd1 : 16'd0, last: 0, exp: (i < 4) ? i + 1 : 0, user: 0, elast: 0};
      t1[2*i+1] = '{din: 16'd10, last: 1, exp: (i == 0) ? 10 : (i == 1) ? 30 : (i == 2) ? 60 : 100,
                    user: 1, elast: 1};
    end
    rt[0] = '{3, 2};       rt[1] = '{-3, -1};     rt[2] = '{1, 1};   rt[3] = '{-1, 0};
    rt[4] = '{0, 0};       rt[5] = '{2, 1};       rt[6] = '{-2, -1}; rt[7] = '{5, 3};
    rt[8] = '{-32768, -16384};                    rt[9] = '{32767, 16384};

    rst = 1'b1;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    s_tdata_b = '0; s_tvalid_b = 1'b0; s_tlast_b = 1'b0; m_tready_b = 1'b1;
    coef_we_b = 1'b0; coef_addr_b = '0; coef_data_b = '0;
    ready_mode = 0;
    model_clear();
    repeat (3) step();
    rst = 1'b0;

    // Reset values
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_tready", s_tready, 1);

    // Per-channel convolution
    load_1234();
    run_conv();
    drain();

    // Rounding on the OUT_SHIFT=1 instance
    coef_we_b = 1'b1; coef_addr_b = 2'd0; coef_data_b = 16'd1;
    step();
    coef_we_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_tdata_b  = 16'(rt[i].din);
      s_tlast_b  = (i % 2 == 1);
      s_tvalid_b = 1'b1;
      step();
      chk("round_valid", m_tvalid_b, 1);
      chk("round_data", longint'($signed(m_tdata_b)), rt[i].exp);
      chk("round_user", m_tuser_b, i % 2);
    end
    s_tvalid_b = 1'b0;
    chk("round_frame_err", frame_err_b, 0);

    // Saturation
    do_reset();
    for (int k = 0; k < NT; k++) set_coef(k, 32'h7FFF);
    for (int i = 0; i < 4; i++) begin
      send_beat(16'h7FFF, i % 2 == 1);
      chk("sat_pos", longint'($signed(m_tdata)), 32767);
    end
    for (int i = 0; i < 8; i++) begin
      send_beat(16'h8000, i % 2 == 1);
      if (i >= 6) chk("sat_neg", longint'($signed(m_tdata)), -32768);
    end
    drain();

    // Backpressure: ready low for 5 cycles while input stays valid
    do_reset();
    load_1234();
    ready_mode = 2;
    stall_end  = cyc + 5;
    send_beat(16'd7, 1'b0);
    chk("bp_valid", m_tvalid, 1);
    chk("bp_tready_low", s_tready, 0);
    for (int i = 1; i < 8; i++) send_beat(16'(i * 37 - 100), i % 2 == 1);
    drain();

    // Framing error: tlast on a channel-0 beat
    do_reset();
    load_1234();
    send_beat(16'd3, 1'b1);
    chk("ferr_set", frame_err, 1);
    send_beat(16'd4, 1'b0);
    chk("ferr_next_ch0", m_tuser, 0);
    send_beat(16'd5, 1'b0);
    chk("ferr_then_ch1", m_tuser, 1);
    chk("ferr_sticky", frame_err, 1);

    // Reset with a pending output beat
    send_beat(16'd9, 1'b1);
    m_tready = 1'b0;
    chk("pre_rst_valid", m_tvalid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", m_tvalid, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_data", m_tdata, 0);
    m_tready = 1'b1;
    load_1234();
    run_conv();
    drain();

    // Coefficient write concurrent with an accept
    do_reset();
    load_1234();
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'd100;
    send_beat(16'd5, 1'b0);
    chk("cw_old_coef", longint'($signed(m_tdata)), 5);
    send_beat(16'd0, 1'b1);
    send_beat(16'd1, 1'b0);
    chk("cw_new_coef", longint'($signed(m_tdata)), 110);
    drain();

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < NT; k++) set_coef(k, int'($urandom_range(0, 600)) - 300);
    ready_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        step();
      end else begin
        logic [15:0] d;
        bit lst;
        if ($urandom_range(0, 7) == 0) begin
          coef_we   = 1'b1;
          coef_addr = 2'($urandom_range(0, NT - 1));
          coef_data = 16'(int'($urandom_range(0, 600)) - 300);
        end
        if ($urandom_range(0, 1) == 0) d = 16'($urandom);
        else d = 16'(int'($urandom_range(0, 2000)) - 1000);
        if (mch == NC - 1) lst = ($urandom_range(0, 9) != 0);
        else lst = ($urandom_range(0, 49) == 0);
        send_beat(d, lst);
      end
    end
    drain();
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
